// File: rtl/if_fetch_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and IF/ID write side.
interface if_fetch_if;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       if_id_en;
  logic       if_id_flush;
  logic [7:0] pc_plus_1;
  logic [7:0] instr;
  logic [7:0] immby;
  logic [7:0] ip;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_en, if_id_flush, pc_plus_1, instr, immby, ip
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_en, if_id_flush, pc_plus_1, instr, immby, ip
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, assembles 1/2-byte instructions for IF/ID.
// Outputs are combinational from state; branch_taken beats stall beats normal fetch.
module if_fetch_unit #(
  parameter logic [3:0] TWO_BYTE_OPC   = 4'hC,
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] NOP_OPC        = 8'h00
) (
  input  logic     clk,
  input  logic     rst,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {S_VEC, S_OP, S_IMM} state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] op_hold_q, op_hold_d;
  logic [7:0] op_addr_q, op_addr_d;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    op_hold_d         = op_hold_q;
    op_addr_d         = op_addr_q;
    bus.imem_addr     = pc_q;
    bus.if_id_en      = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.instr         = NOP_OPC;
    bus.immby         = 8'h00;
    bus.ip            = 8'h00;
    bus.pc_plus_1     = 8'h00;

    case (state_q)
      S_VEC: begin
        bus.imem_addr = RESET_VEC_ADDR;
        pc_d          = bus.branch_taken ? bus.branch_target : bus.imem_rdata;
        state_d       = S_OP;
      end

      S_OP: begin
        if (bus.branch_taken) begin
          pc_d            = bus.branch_target;
          bus.if_id_flush = 1'b1;
        end else if (!bus.stall) begin
          if (bus.imem_rdata[7:4] == TWO_BYTE_OPC) begin
            // Bubble IF/ID while the immediate is fetched so it never sees half an instruction.
            op_hold_d       = bus.imem_rdata;
            op_addr_d       = pc_q;
            pc_d            = pc_q + 8'd1;
            state_d         = S_IMM;
            bus.if_id_flush = 1'b1;
          end else begin
            bus.if_id_en  = 1'b1;
            bus.instr     = bus.imem_rdata;
            bus.ip        = pc_q;
            bus.pc_plus_1 = pc_q + 8'd1;
            pc_d          = pc_q + 8'd1;
          end
        end
      end

      S_IMM: begin
        if (bus.branch_taken) begin
          pc_d            = bus.branch_target;
          op_hold_d       = NOP_OPC;
          state_d         = S_OP;
          bus.if_id_flush = 1'b1;
        end else if (!bus.stall) begin
          bus.if_id_en  = 1'b1;
          bus.instr     = op_hold_q;
          bus.immby     = bus.imem_rdata;
          bus.ip        = op_addr_q;
          bus.pc_plus_1 = pc_q + 8'd1;
          pc_d          = pc_q + 8'd1;
          state_d       = S_OP;
        end
      end

      default: state_d = S_VEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_VEC;
      pc_q      <= 8'h00;
      op_hold_q <= NOP_OPC;
      op_addr_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_hold_q <= op_hold_d;
      op_addr_q <= op_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios plus a randomized run against an instruction-stream reference model.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_if bus ();

  if_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.imem_rdata = mem[bus.imem_addr];

  // {en, flush, imem_addr, instr, immby, ip, pc_plus_1}
  wire [41:0] obs = {bus.if_id_en, bus.if_id_flush, bus.imem_addr, bus.instr,
                     bus.immby, bus.ip, bus.pc_plus_1};

  task automatic drive(input logic s, input logic b, input logic [7:0] t);
    @(negedge clk);
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
    #1;
  endtask

  task automatic do_reset(input logic [7:0] vec);
    @(negedge clk);
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 8'h00;
    mem[0] = vec;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h21;
    mem[0] = 8'h10;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 8'h00;
    rst = 1'b0;
    #12;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", obs, {2'b00, 40'h0});
    end
    @(negedge clk); rst = 1'b1; #1;
    n_tests++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL vec_cycle: got %h want %h", obs, {2'b00, 40'h0});
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h10, 8'h21, 8'h00, 8'h10, 8'h11}) begin
      n_fail++; $display("FAIL vec_first_instr: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h10, 8'h21, 8'h00, 8'h10, 8'h11});
    end
  endtask

  task automatic test_two_byte;
    mem[8'h20] = 8'hC3; mem[8'h21] = 8'h5A;
    do_reset(8'h20);
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL two_byte_bubble: got %h want %h", obs,
                         {1'b0, 1'b1, 8'h20, 32'h0});
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h21, 8'hC3, 8'h5A, 8'h20, 8'h22}) begin
      n_fail++; $display("FAIL two_byte_deliver: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h21, 8'hC3, 8'h5A, 8'h20, 8'h22});
    end
  endtask

  task automatic test_stall_imm;
    mem[8'h20] = 8'hC3; mem[8'h21] = 8'h5A; mem[8'h22] = 8'h01;
    do_reset(8'h20);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      n_tests++;
      if (obs !== {1'b0, 1'b0, 8'h21, 32'h0}) begin
        n_fail++; $display("FAIL stall_imm_%0d: got %h want %h", i, obs, {2'b00, 8'h21, 32'h0});
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h21, 8'hC3, 8'h5A, 8'h20, 8'h22}) begin
      n_fail++; $display("FAIL stall_release: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h21, 8'hC3, 8'h5A, 8'h20, 8'h22});
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h22, 8'h01, 8'h00, 8'h22, 8'h23}) begin
      n_fail++; $display("FAIL stall_once: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h22, 8'h01, 8'h00, 8'h22, 8'h23});
    end
  endtask

  task automatic test_branch;
    mem[8'h20] = 8'hC3; mem[8'h21] = 8'h5A; mem[8'h40] = 8'h07;
    do_reset(8'h20);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h40);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 8'h21, 32'h0}) begin
      n_fail++; $display("FAIL branch_flush: got %h want %h", obs, {2'b01, 8'h21, 32'h0});
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h40, 8'h07, 8'h00, 8'h40, 8'h41}) begin
      n_fail++; $display("FAIL branch_target: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h40, 8'h07, 8'h00, 8'h40, 8'h41});
    end
  endtask

  task automatic test_wrap;
    mem[8'hFF] = 8'h33;
    do_reset(8'hFF);
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'hFF, 8'h33, 8'h00, 8'hFF, 8'h00}) begin
      n_fail++; $display("FAIL wrap_one_byte: got %h want %h", obs,
                         {1'b1, 1'b0, 8'hFF, 8'h33, 8'h00, 8'hFF, 8'h00});
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01}) begin
      n_fail++; $display("FAIL wrap_next_addr: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01});
    end
    mem[8'hFF] = 8'hC9;
    do_reset(8'hFF);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 8'h00, 8'hC9, 8'hFF, 8'hFF, 8'h01}) begin
      n_fail++; $display("FAIL wrap_two_byte: got %h want %h", obs,
                         {1'b1, 1'b0, 8'h00, 8'hC9, 8'hFF, 8'hFF, 8'h01});
    end
  endtask

  task automatic test_async_reset;
    mem[8'h20] = 8'hC3; mem[8'h21] = 8'h5A;
    do_reset(8'h20);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (obs !== 42'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, 42'h0);
    end
    @(negedge clk); rst = 1'b1; #1;
    n_tests++;
    if (obs !== 42'h0) begin
      n_fail++; $display("FAIL async_vec_again: got %h want %h", obs, 42'h0);
    end
    drive(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (obs !== {1'b0, 1'b1, 8'h20, 32'h0}) begin
      n_fail++; $display("FAIL async_refetch: got %h want %h", obs, {2'b01, 8'h20, 32'h0});
    end
  endtask

  task automatic test_random;
    logic [7:0] m_pc, m_op, m_opaddr, d, tgt;
    logic       m_pend, s, b;
    logic [41:0] exp;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? {4'hC, 4'($urandom)} : 8'($urandom);
    do_reset(mem[0]);
    m_pc = mem[0]; m_pend = 1'b0; m_op = 8'h00; m_opaddr = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 9) == 0);
      tgt = 8'($urandom);
      drive(s, b, tgt);
      d   = mem[m_pc];
      exp = {2'b00, m_pc, 32'h0};
      if (b) begin
        exp[40] = 1'b1;
        m_pc = tgt; m_pend = 1'b0;
      end else if (s) begin
        // everything holds
      end else if (m_pend) begin
        exp = {1'b1, 1'b0, m_pc, m_op, d, m_opaddr, m_pc + 8'd1};
        m_pc = m_pc + 8'd1; m_pend = 1'b0;
      end else if (d[7:4] == 4'hC) begin
        exp[40] = 1'b1;
        m_op = d; m_opaddr = m_pc; m_pc = m_pc + 8'd1; m_pend = 1'b1;
      end else begin
        exp = {1'b1, 1'b0, m_pc, d, 8'h00, m_pc, m_pc + 8'd1};
        m_pc = m_pc + 8'd1;
      end
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %h want %h", c, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_stall_imm();
    test_branch();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
